pio_edge_irq: RTL
=================

// Module: pio_edge_irq
// PURPOSE
//  Parametrised Avalon-MM PIO, successor to the single-register input PIO in the image viewer.
//  Provides a synchronised input port, a per-bit edge-capture register and a maskable IRQ.
//  Also provides an output port with set/clear aliases. Sits on the Nios II data bus.
//  Typical uses: buttons and switches in, image-select and LED lines out.
// PARAMETERS
//  DATA_WIDTH   32   width of in_port, out_port and all registers (1..32)
//  SYNC_STAGES  2    flops in the in_port synchroniser (2..3)
//  EDGE_TYPE    0    0 = rising edge, 1 = falling edge, 2 = any edge captured
//  OUT_RESET    0    reset value of out_port (DATA_WIDTH bits)
// PORTS
//  clk         in   1           system clock
//  reset_n     in   1           async active-low reset
//  address     in   3           word address
//  chipselect  in   1           slave select
//  write_n     in   1           active-low write strobe, qualified by chipselect
//  writedata   in   32          write data; bits >= DATA_WIDTH ignored
//  readdata    out  32          registered read data; bits >= DATA_WIDTH read 0
//  in_port     in   DATA_WIDTH  asynchronous external inputs
//  out_port    out  DATA_WIDTH  output register
//  irq         out  1           level interrupt, = |(edge_cap & irq_mask)
// BEHAVIOUR
//  Reset (async, reset_n=0): all registers clear -> readdata=0, irq=0, out_port=OUT_RESET.
//   Cleared: irq_mask=0, edge_cap=0, sync chain=0, prev=0, warm-up counter=0.
//  Register map (write = chipselect & ~write_n):
//   0 DATA     R: synchronised input (sync_q); W: out_reg <= writedata
//   1 IRQMASK  R/W: irq_mask
//   2 EDGECAP  R: edge_cap; W: bits written 1 are cleared, bits written 0 unchanged
//   3 OUTSET   R: out_reg; W: out_reg <= out_reg | writedata
//   4 OUTCLR   R: out_reg; W: out_reg <= out_reg & ~writedata
//   5..7       R: 0; W: ignored
//  Read: readdata <= mux(address), updated every clk regardless of chipselect.
//   Read latency is 1 cycle.
//  Sync: sync_q = last stage of SYNC_STAGES flops; prev <= sync_q every clk.
//   Edge detect: rise = sync_q & ~prev; fall = ~sync_q & prev; select by EDGE_TYPE.
//  Latency (SYNC_STAGES=2): in_port change sampled at edge k.
//   sync_q updates at k+1; edge_cap bit set at k+2; irq high after k+2.
//  Warm-up: counter runs 0..SYNC_STAGES+1 after reset release, then saturates.
//   Edge capture is suppressed until saturation, so no spurious edge from static-high inputs.
//   DATA reads and writes work during warm-up.
//  edge_cap bit is sticky: set by a detected edge, held until a software write-1-to-clear.
//  Simultaneous edge and W1C on the same bit: set wins, bit stays 1.
//  irq_mask change takes effect on irq the cycle after the write; edge_cap is unaffected.
//  Mid-operation reset: all state is discarded immediately; warm-up restarts on release.
//  out_port is driven directly from out_reg; no glitch on unrelated writes.
// STRUCTURE
//  Shared package pio_pkg holds:
//   - address constants ADDR_DATA..ADDR_OUTCLR
//   - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
//  Sub-module pio_sync_chain (DATA_WIDTH x SYNC_STAGES flop chain, async reset to 0).
//  Top holds: warm-up counter, edge logic, register file, read mux.
// TESTING
//  1 Reset with in_port=0xFFFF_FFFF held high, EDGE_TYPE=0, then release.
//    -> EDGECAP reads 0 and irq stays 0 for 20 cycles; DATA reads 0xFFFF_FFFF.
//  2 Write IRQMASK=0x1; drive in_port[0] 0->1 at edge k (SYNC_STAGES=2).
//    -> EDGECAP=0x1 at k+2, irq=1 at k+2.
//    -> Write EDGECAP=0x1 -> irq=0 the next cycle.
//  3 In-port edge on bit 3 in the same cycle as a W1C of 0x8 to EDGECAP.
//    -> bit 3 stays 1.
//    -> A second W1C clears it.
//  4 Write DATA=0xA5, OUTSET=0x0F00, OUTCLR=0x0005.
//    -> out_port=0x0FA0; reading address 3 returns 0x0FA0 one cycle later.
//  5 EDGE_TYPE=2, mask=0: pulse in_port[7] 1 then 0.
//    -> EDGECAP=0x80 and irq=0.
//    -> Set mask=0x80 -> irq=1 the next cycle.
//  6 Assert reset_n low mid-test with EDGECAP=0x80 and out_port=0x0FA0.
//    -> readdata, edge_cap and irq clear immediately; out_port=OUT_RESET.
//    -> Read of address 6 returns 0.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the edge-capturing PIO: register map and edge-type encodings.
package pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA    = 3'd0,
        ADDR_IRQMASK = 3'd1,
        ADDR_EDGECAP = 3'd2,
        ADDR_OUTSET  = 3'd3,
        ADDR_OUTCLR  = 3'd4
    } reg_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Single-bit edge qualifier; cur is the synchronised level, old the previous one.
    function automatic logic edge_hit(input int edge_type, input logic cur, input logic old);
        case (edge_type)
            EDGE_RISE: return cur & ~old;
            EDGE_FALL: return ~cur & old;
            default:   return cur ^ old;
        endcase
    endfunction

endpackage

// File: rtl/pio_sync_chain.sv
// Per-bit multi-flop synchroniser for asynchronous PIO inputs; clears to 0 on reset.
module pio_sync_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [STAGES-1:0] chain_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[STAGES-2:0], d[gi]};
                end
            end

            assign q[gi] = chain_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM PIO: synchronised input port with sticky per-bit edge capture and maskable
// level IRQ, plus an output register with set/clear aliases.
module pio_edge_irq
    import pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = 0,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_reg;
    logic [DATA_WIDTH-1:0] edge_vec;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] clr_bits;
    logic [DATA_WIDTH-1:0] mask_reg, mask_next;
    logic [DATA_WIDTH-1:0] cap_reg,  cap_next;
    logic [DATA_WIDTH-1:0] out_reg,  out_next;
    logic [31:0]           readdata_reg, readdata_next;
    logic [2:0]            warm_reg;
    logic                  warm_done;
    logic                  wr_en;

    pio_sync_chain #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_q)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
            assign edge_vec[gi] = edge_hit(EDGE_TYPE, sync_q[gi], prev_reg[gi]);
        end
    endgenerate

    // Capture stays off until the chain and prev hold real samples, so inputs that are
    // already high at reset release never look like a fresh rising edge.
    assign warm_done = (warm_reg == WARM_MAX);
    assign wr_en     = chipselect & ~write_n;
    assign wdata     = writedata[DATA_WIDTH-1:0];

    always_comb begin
        mask_next = mask_reg;
        out_next  = out_reg;
        clr_bits  = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:    out_next  = wdata;
                ADDR_IRQMASK: mask_next = wdata;
                ADDR_EDGECAP: clr_bits  = wdata;
                ADDR_OUTSET:  out_next  = out_reg | wdata;
                ADDR_OUTCLR:  out_next  = out_reg & ~wdata;
                default:      ;
            endcase
        end
        // New edges are OR'd after the clear so a coincident edge survives the W1C.
        cap_next = (cap_reg & ~clr_bits) | (warm_done ? edge_vec : '0);
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:    readdata_next[DATA_WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: readdata_next[DATA_WIDTH-1:0] = mask_reg;
            ADDR_EDGECAP: readdata_next[DATA_WIDTH-1:0] = cap_reg;
            ADDR_OUTSET,
            ADDR_OUTCLR:  readdata_next[DATA_WIDTH-1:0] = out_reg;
            default:      readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_reg     <= '0;
            prev_reg     <= '0;
            mask_reg     <= '0;
            cap_reg      <= '0;
            out_reg      <= OUT_RESET;
            readdata_reg <= '0;
        end else begin
            if (!warm_done) begin
                warm_reg <= warm_reg + 3'd1;
            end
            prev_reg     <= sync_q;
            mask_reg     <= mask_next;
            cap_reg      <= cap_next;
            out_reg      <= out_next;
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign out_port = out_reg;
    assign irq      = |(cap_reg & mask_reg);

endmodule
